// File: rtl/store_buffer_if.sv
// Purpose : Bundles the store-buffer handshake and memory-port signals so the
//           MEM-stage side and the Data_Memory side connect through one port.
// Signals :
//   st_valid/st_addr/st_data/st_ready : store enqueue handshake from MEM stage
//   ld_valid/ld_addr/ld_ready/ld_data : doubleword load from MEM stage
//   drain_req/empty                   : fence request and FIFO-empty status
//   misalign                          : active op has addr[2:0] != 0
//   mem_addr/mem_wdata/mem_write/mem_read/mem_rdata : Data_Memory port
// Modports:
//   slave  - the store buffer itself
//   master - the pipeline plus memory that surround it
interface store_buffer_if;
  logic        st_valid;
  logic [63:0] st_addr;
  logic [63:0] st_data;
  logic        st_ready;
  logic        ld_valid;
  logic [63:0] ld_addr;
  logic        ld_ready;
  logic [63:0] ld_data;
  logic        drain_req;
  logic        empty;
  logic        misalign;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_write;
  logic        mem_read;
  logic [63:0] mem_rdata;

  modport slave (
    input  st_valid, st_addr, st_data, ld_valid, ld_addr, drain_req, mem_rdata,
    output st_ready, ld_ready, ld_data, empty, misalign,
           mem_addr, mem_wdata, mem_write, mem_read
  );

  modport master (
    output st_valid, st_addr, st_data, ld_valid, ld_addr, drain_req, mem_rdata,
    input  st_ready, ld_ready, ld_data, empty, misalign,
           mem_addr, mem_wdata, mem_write, mem_read
  );
endinterface

// File: rtl/store_buffer.sv
// Purpose : Posted-write store buffer between the EX/MEM pipeline register and
//           Data_Memory. Stores are queued in a FIFO in one cycle and drained
//           to memory whenever no load needs the port. Loads read memory
//           combinationally, with the youngest matching buffered store
//           forwarded over the memory data.
// Ports   :
//   clk   - clock, all state updates on posedge
//   reset - asynchronous, active-low reset
//   bus   - store_buffer_if.slave (store/load handshakes, fence, memory port)
// Parameters:
//   DEPTH        - FIFO entries (power of 2, >= 2)
//   STARVE_LIMIT - consecutive load-blocked cycles before a forced drain
module store_buffer #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic           clk,
  input  logic           reset,
  store_buffer_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    OPP,
    FORCE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [SW-1:0] starve_q, starve_d;

  logic [63:0]   entryAddr_q [DEPTH];
  logic [63:0]   entryData_q [DEPTH];

  logic          stReady;
  logic          push;
  logic          pop;
  logic          ldReady;
  logic          fwdHit;
  logic [63:0]   fwdData;

  // Acceptance looks only at the registered count, so a pop in this cycle
  // never frees a slot for a push in the same cycle.
  assign stReady = (count_q < DEPTH_C) && !bus.drain_req;
  assign push    = bus.st_valid && stReady;

  // Drain/load arbitration for the single memory port. The FSM decides who
  // owns the port; a load is only starved out for one cycle in FORCE.
  always_comb begin
    state_d       = state_q;
    starve_d      = starve_q;
    pop           = 1'b0;
    ldReady       = 1'b1;
    bus.mem_write = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_addr  = 64'd0;
    bus.mem_wdata = 64'd0;

    case (state_q)
      IDLE: begin
        if (push) begin
          state_d = OPP;
        end
      end
      OPP: begin
        if (bus.ld_valid) begin
          starve_d = starve_q + SW'(1);
          if (starve_d == LIMIT_C) begin
            state_d = FORCE;
          end
        end else begin
          pop      = 1'b1;
          starve_d = '0;
        end
      end
      FORCE: begin
        ldReady  = 1'b0;
        pop      = 1'b1;
        starve_d = '0;
        state_d  = OPP;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (pop) begin
      bus.mem_write = 1'b1;
      bus.mem_addr  = entryAddr_q[head_q];
      bus.mem_wdata = entryData_q[head_q];
    end else if (bus.ld_valid && ldReady) begin
      bus.mem_read = 1'b1;
      bus.mem_addr = bus.ld_addr;
    end

    // A drain that empties the FIFO without a refilling push returns to IDLE.
    if (state_q != IDLE && count_d == '0) begin
      state_d = IDLE;
    end
  end

  // Occupancy and pointer bookkeeping; push and pop together leave the count
  // unchanged while both pointers advance.
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (push) begin
      tail_d = tail_q + PW'(1);
    end
    if (pop) begin
      head_d = head_q + PW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  // Forwarding search walks the entries present at the start of the cycle
  // from oldest to youngest, so the last match is the youngest store. The
  // head entry is still searched while it pops.
  always_comb begin
    logic [PW-1:0] idx;
    fwdHit  = 1'b0;
    fwdData = 64'd0;
    idx     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if ((CW'(i) < count_q) && (entryAddr_q[idx] == bus.ld_addr)) begin
        fwdHit  = 1'b1;
        fwdData = entryData_q[idx];
      end
    end
  end

  assign bus.st_ready = stReady;
  assign bus.ld_ready = ldReady;
  assign bus.ld_data  = fwdHit ? fwdData : bus.mem_rdata;
  assign bus.empty    = (count_q == '0);
  assign bus.misalign = (bus.ld_valid && (bus.ld_addr[2:0] != 3'd0)) ||
                        (bus.st_valid && (bus.st_addr[2:0] != 3'd0));

  // Control state; reset discards any buffered stores so nothing further
  // reaches memory.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      starve_q <= starve_d;
    end
  end

  // Entry storage needs no reset: validity is defined by head/count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      entryAddr_q[tail_q] <= bus.st_addr;
      entryData_q[tail_q] <= bus.st_data;
    end
  end

endmodule
